wall_column_gen: RTL and testbench
==================================

Name: wall_column_gen

Overview:
- Upstream map source for the game datapath.
- Produces one 100-bit wall column per request for the datapath's PHYSICS-state shift. That column is loaded into the rightmost vwall column, and its OR feeds hwall.
- Builds a deterministic, level-scaled stream of alternating empty runs and wall segments using a 16-bit LFSR.
- Replaces the fixed which-toggled wall patterns.

Parameters:
- COL_H, 100, bits per column (vertical playfield height).
- SEED, 16'hACE1, LFSR value loaded on start.
- WALL_RUN, 4, columns per wall segment (identical pattern).
- EMPTY_BASE, 24, empty-run length at level 0.
- LEVEL_COLS, 64, columns served per level increment.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse from control on MENU->game; (re)initialises the generator.
- req  input  1  one-cycle pulse from datapath: consume current column.
- col_valid  output  1  col_data holds an unconsumed column.
- col_data  output  COL_H  next wall column; bit 0 = bottom row.
- col_has_wall  output  1  |col_data, registered with col_data (hwall bit).
- level  output  3  difficulty level, saturates at 7.
- col_count  output  16  columns consumed since start, wraps at 65535->0.
- req_miss  output  1  sticky: req seen while col_valid=0.

Behaviour:
- Reset (async, resetn=0): all outputs 0. FSM=IDLE, lfsr=SEED, run counter 0, phase=EMPTY, pattern=FLOOR.
- FSM states:
  - IDLE: col_valid=0; req ignored, does not set req_miss; start -> FILL.
  - FILL: exactly one cycle. Registers the next column into col_data/col_has_wall, updates phase/run counter -> READY.
  - READY: col_valid=1. req -> FILL, col_count+1, level update. start -> FILL with re-init.
- start, from any state: lfsr<=SEED, col_count<=0, level<=0, req_miss<=0, phase<=EMPTY, run<=EMPTY_BASE, next state FILL. start wins over a simultaneous req, which is then discarded and not counted.
- Latency:
  - req sampled at edge k: col_valid=0 after k; col_valid=1 with the new column after k+1.
  - start at edge k: first column valid after k+1.
- Phase sequencing, evaluated in FILL:
  - EMPTY phase: column = all 0s; run decrements.
  - When run reaches 0 after emitting, phase -> WALL, run<=WALL_RUN. The LFSR advances once and pattern<=lfsr_next[1:0].
  - WALL phase: column = pattern; run decrements.
  - When run reaches 0, phase -> EMPTY, run<=EMPTY_BASE-2*level, using level at that moment.
- LFSR: Galois, right shift, tap mask 16'hB400. Next value = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0). Advances only on WALL entry.
- Patterns (pattern code: set bits):
  - 0 FLOOR: [19:0].
  - 1 CEIL: [99:80].
  - 2 MID: [69:30].
  - 3 BOTH: [19:0] and [99:80].
  - Every pattern leaves at least 20 clear rows (the dude is 6 tall).
- Level: increments when col_count reaches a nonzero multiple of LEVEL_COLS; saturates at 7. Minimum empty run is EMPTY_BASE-14=10.
- req while col_valid=0 (FILL state): req_miss<=1 and stays set until start or reset. The req is not counted and FILL proceeds normally.
- col_data holds its value while in READY; it changes only on the FILL->READY edge or on reset.
- Reset mid-FILL: outputs clear immediately; a partially computed column never appears.

Test Plan:
- Reset: hold resetn=0 for 3 cycles -> col_valid=0, col_data=0, level=0, col_count=0, req_miss=0. Apply req in IDLE -> no change, req_miss stays 0.
- start pulse, then 24 req pulses spaced 5 cycles -> every column 0 with col_has_wall=0. Next 4 columns: col_data[19:0]=20'hFFFFF, rest 0, col_has_wall=1 (lfsr 0xACE1 -> 0xE270, code 0 FLOOR). Then 0x7138, code 0 gives FLOOR for the second segment.
- Latency: req at edge k -> col_valid low after k, high after k+1. Back-to-back req on the cycle after k -> req_miss=1, col_count unchanged.
- Level: serve 64 columns -> level=1, col_count=64. The next empty run starting after that is 22 columns. Serve to 448+ columns -> level holds 7, empty runs are 10.
- start asserted together with req while in READY, after 30 columns -> col_count=0, level=0, req_miss cleared. The following stream exactly repeats the post-reset stream.
- Drop resetn asynchronously mid-FILL, with no clock edge -> outputs 0 immediately. After release plus start -> stream identical to the first run.

Source files
------------

// File: rtl/wall_column_gen_if.sv
// Handshake and column bus between the map generator and the game datapath.
// The master side is the consumer (control/datapath); the slave side is the generator.
interface wall_column_gen_if #(
    parameter int COL_H = 100
);
    logic             start;
    logic             req;
    logic             col_valid;
    logic [COL_H-1:0] col_data;
    logic             col_has_wall;
    logic [2:0]       level;
    logic [15:0]      col_count;
    logic             req_miss;

    modport master (
        output start, req,
        input  col_valid, col_data, col_has_wall, level, col_count, req_miss
    );

    modport slave (
        input  start, req,
        output col_valid, col_data, col_has_wall, level, col_count, req_miss
    );
endinterface

// File: rtl/wall_column_gen.sv
// Level-scaled wall column source: alternating empty runs and LFSR-chosen wall
// segments, one column per request, served through a IDLE/FILL/READY handshake.
module wall_column_gen #(
    parameter int          COL_H      = 100,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          WALL_RUN   = 4,
    parameter int          EMPTY_BASE = 24,
    parameter int          LEVEL_COLS = 64
) (
    input logic              clk,
    input logic              resetn,
    wall_column_gen_if.slave bus
);
    localparam int          BAND         = 20;
    localparam int          MID_LO       = 30;
    localparam int          MID_HI       = 69;
    localparam logic [15:0] TAPS         = 16'hB400;
    localparam logic [15:0] LEVEL_COLS_W = 16'(LEVEL_COLS);

    typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [7:0]       run;
    logic [7:0]       empty_len;
    logic             wall_phase;
    logic [1:0]       pattern;
    logic [COL_H-1:0] fill_col;
    logic [15:0]      cnt_next;
    logic             level_up;
    logic             valid;

    function automatic logic [COL_H-1:0] pattern_col(input logic [1:0] code);
        logic [COL_H-1:0] c;
        c = '0;
        for (int r = 0; r < COL_H; r++) begin
            case (code)
                2'd0:    c[r] = (r < BAND);
                2'd1:    c[r] = (r >= COL_H - BAND);
                2'd2:    c[r] = (r >= MID_LO) && (r <= MID_HI);
                default: c[r] = (r < BAND) || (r >= COL_H - BAND);
            endcase
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // start overrides every state, including a req arriving on the same edge
    always_comb begin
        state_next = state;
        valid      = 1'b0;
        case (state)
            IDLE:    state_next = IDLE;
            FILL:    state_next = READY;
            READY: begin
                valid = 1'b1;
                if (bus.req) state_next = FILL;
            end
            default: state_next = IDLE;
        endcase
        if (bus.start) state_next = FILL;
    end

    assign bus.col_valid = valid;

    always_comb begin
        lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
        fill_col  = wall_phase ? pattern_col(pattern) : '0;
        empty_len = 8'(EMPTY_BASE) - {4'd0, bus.level, 1'b0};
        cnt_next  = bus.col_count + 16'd1;
        level_up  = (cnt_next % LEVEL_COLS_W == 16'd0) && (cnt_next != 16'd0)
                    && (bus.level != 3'd7);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr             <= SEED;
            run              <= '0;
            wall_phase       <= 1'b0;
            pattern          <= 2'd0;
            bus.col_data     <= '0;
            bus.col_has_wall <= 1'b0;
            bus.level        <= '0;
            bus.col_count    <= '0;
            bus.req_miss     <= 1'b0;
        end else if (bus.start) begin
            lfsr          <= SEED;
            run           <= 8'(EMPTY_BASE);
            wall_phase    <= 1'b0;
            bus.level     <= '0;
            bus.col_count <= '0;
            bus.req_miss  <= 1'b0;
        end else if (state == FILL) begin
            if (bus.req) bus.req_miss <= 1'b1;
            bus.col_data     <= fill_col;
            bus.col_has_wall <= |fill_col;
            if (run <= 8'd1) begin
                if (wall_phase) begin
                    wall_phase <= 1'b0;
                    run        <= empty_len;
                end else begin
                    wall_phase <= 1'b1;
                    run        <= 8'(WALL_RUN);
                    lfsr       <= lfsr_next;
                    pattern    <= lfsr_next[1:0];
                end
            end else begin
                run <= run - 8'd1;
            end
        end else if (state == READY && bus.req) begin
            bus.col_count <= cnt_next;
            if (level_up) bus.level <= bus.level + 3'd1;
        end
    end
endmodule

// File: tb/tb_wall_column_gen.sv
// Directed-sequence bench with randomized request spacing; expected columns come
// from a segment-level model of the empty/wall stream built before stimulus.
module tb_wall_column_gen;
    localparam int MAXC = 620;

    logic clk;
    logic resetn;
    int   passed;
    int   total;
    int   cur;

    logic [99:0] exp_col [1:MAXC];

    wall_column_gen_if #(.COL_H(100)) bus ();

    wall_column_gen dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [99:0] pat(input logic [1:0] code);
        logic [99:0] c;
        c = '0;
        case (code)
            2'd0: c[19:0] = '1;
            2'd1: c[99:80] = '1;
            2'd2: c[69:30] = '1;
            default: begin
                c[19:0]  = '1;
                c[99:80] = '1;
            end
        endcase
        return c;
    endfunction

    function automatic int lvl_after(input int consumed);
        return (consumed / 64 > 7) ? 7 : consumed / 64;
    endfunction

    // Stream as segments: empty run, then LFSR step and 4 wall columns; the next
    // empty run length uses the level in force when the last wall column was built.
    task automatic build_model();
        logic [15:0] lf;
        int          n;
        int          elen;
        lf   = 16'hACE1;
        n    = 0;
        elen = 24;
        while (n < MAXC) begin
            for (int e = 0; e < elen && n < MAXC; e++) begin
                n++;
                exp_col[n] = '0;
            end
            lf = (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
            for (int w = 0; w < 4 && n < MAXC; w++) begin
                n++;
                exp_col[n] = pat(lf[1:0]);
            end
            elen = 24 - 2 * lvl_after(n - 1);
        end
    endtask

    task automatic wait_valid();
        int cyc;
        cyc = 0;
        while (bus.col_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 20) check("valid_timeout", bus.col_valid, 1'b1);
    endtask

    task automatic serve(input int count);
        for (int i = 0; i < count; i++) begin
            wait_valid();
            check("col_data", bus.col_data, exp_col[cur]);
            check("col_has_wall", bus.col_has_wall, |exp_col[cur]);
            bus.req = 1'b1;
            @(negedge clk);
            bus.req = 1'b0;
            check("col_count", bus.col_count, cur);
            check("level", bus.level, lvl_after(cur));
            cur++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cur = 1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        cur       = 1;
        bus.start = 1'b0;
        bus.req   = 1'b0;
        resetn    = 1'b0;
        build_model();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", bus.col_valid, 1'b0);
        check("rst_data", bus.col_data, '0);
        check("rst_level", bus.level, 3'd0);
        check("rst_count", bus.col_count, 16'd0);
        check("rst_miss", bus.req_miss, 1'b0);
        resetn = 1'b1;
        @(negedge clk);

        // req in IDLE is ignored
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        check("idle_valid", bus.col_valid, 1'b0);
        check("idle_miss", bus.req_miss, 1'b0);
        check("idle_count", bus.col_count, 16'd0);

        // start latency: invalid after k, valid after k+1
        pulse_start();
        check("start_lat0", bus.col_valid, 1'b0);
        @(negedge clk);
        check("start_lat1", bus.col_valid, 1'b1);

        serve(24);
        wait_valid();
        check("first_floor", bus.col_data, {80'd0, 20'hFFFFF});
        serve(8);

        // req latency, then a back-to-back req landing in FILL
        wait_valid();
        bus.req = 1'b1;
        @(negedge clk);
        check("req_lat0", bus.col_valid, 1'b0);
        check("req_count", bus.col_count, cur);
        @(negedge clk);
        bus.req = 1'b0;
        check("req_lat1", bus.col_valid, 1'b1);
        check("miss_set", bus.req_miss, 1'b1);
        check("miss_count", bus.col_count, cur);
        cur++;
        serve(2);

        // start together with req in READY: re-init wins, req not counted
        wait_valid();
        bus.start = 1'b1;
        bus.req   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.req   = 1'b0;
        cur       = 1;
        check("restart_count", bus.col_count, 16'd0);
        check("restart_level", bus.level, 3'd0);
        check("restart_miss", bus.req_miss, 1'b0);
        check("restart_valid", bus.col_valid, 1'b0);

        // Long replay across all level steps up to saturation
        serve(600);
        check("sat_level", bus.level, 3'd7);

        // Asynchronous reset in the middle of FILL
        wait_valid();
        bus.req = 1'b1;
        @(posedge clk);
        #2;
        bus.req = 1'b0;
        resetn  = 1'b0;
        #1;
        check("arst_valid", bus.col_valid, 1'b0);
        check("arst_data", bus.col_data, '0);
        check("arst_wall", bus.col_has_wall, 1'b0);
        check("arst_count", bus.col_count, 16'd0);
        check("arst_level", bus.level, 3'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        pulse_start();
        serve(60);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
